// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column sequencer, row synchroniser, ghost rejection
// and a debounce FSM that presents a stable key code for the MMIO read port.
module keypad_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clkb,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [4:0] kb_idx,
    output logic       key_pulse
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

    // Key code for flat index r*4+c
    function automatic logic [3:0] key_code(input int idx);
        logic [3:0] code;
        case (idx)
            0: code = 4'd1;   1: code = 4'd2;   2: code = 4'd3;   3: code = 4'd10;
            4: code = 4'd4;   5: code = 4'd5;   6: code = 4'd6;   7: code = 4'd11;
            8: code = 4'd7;   9: code = 4'd8;  10: code = 4'd9;  11: code = 4'd12;
            12: code = 4'd14; 13: code = 4'd0; 14: code = 4'd15; default: code = 4'd13;
        endcase
        return code;
    endfunction

    logic [3:0]       rows_meta_reg;
    logic [3:0]       rows_sync_reg;
    logic [DIV_W-1:0] div_reg;
    logic [1:0]       col_reg;
    logic [3:0]       cols_reg;
    logic             eval_reg;
    logic [3:0]       hit_reg [4];
    logic             sample;

    logic [15:0]      hit_flat;
    logic [3:0]       code_tbl [16];
    logic [4:0]       hit_count;
    logic [3:0]       scan_code;
    logic             scan_single;

    state_t           state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [3:0]       cand_reg, cand_next;
    logic [4:0]       kb_idx_reg, kb_idx_next;
    logic             key_pulse_reg, key_pulse_next;

    // Raw rows are only ever seen by the first synchroniser flop.
    always_ff @(posedge clkb) begin
        if (rst) begin
            rows_meta_reg <= 4'hf;
            rows_sync_reg <= 4'hf;
        end else begin
            rows_meta_reg <= rows;
            rows_sync_reg <= rows_meta_reg;
        end
    end

    assign sample = (div_reg == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clkb) begin
        if (rst) begin
            div_reg  <= '0;
            col_reg  <= 2'd0;
            cols_reg <= 4'b1110;
            eval_reg <= 1'b0;
        end else begin
            eval_reg <= sample && (col_reg == 2'd3);
            if (sample) begin
                div_reg  <= '0;
                col_reg  <= col_reg + 2'd1;
                cols_reg <= ~(4'b0001 << (col_reg + 2'd1));
            end else begin
                div_reg <= div_reg + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clkb) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) hit_reg[c] <= 4'h0;
        end else if (sample) begin
            hit_reg[col_reg] <= ~rows_sync_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_flat
            assign hit_flat[gi] = hit_reg[gi % 4][gi / 4];
            assign code_tbl[gi] = key_code(gi);
        end
    endgenerate

    always_comb begin
        hit_count = 5'd0;
        scan_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (hit_flat[i]) begin
                hit_count = hit_count + 5'd1;
                scan_code = code_tbl[i];
            end
        end
    end

    // Ghosted (multi-key) scans fall through as "no key".
    assign scan_single = (hit_count == 5'd1);

    always_ff @(posedge clkb) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            cand_reg      <= 4'd0;
            kb_idx_reg    <= 5'd0;
            key_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            cand_reg      <= cand_next;
            kb_idx_reg    <= kb_idx_next;
            key_pulse_reg <= key_pulse_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        cand_next      = cand_reg;
        kb_idx_next    = kb_idx_reg;
        key_pulse_next = 1'b0;
        if (eval_reg) begin
            case (state_reg)
                IDLE: begin
                    if (scan_single) begin
                        cand_next = scan_code;
                        cnt_next  = 4'd1;
                        if (DEBOUNCE == 1) begin
                            state_next     = HELD;
                            kb_idx_next    = {1'b1, scan_code};
                            key_pulse_next = 1'b1;
                        end else begin
                            state_next = PRESS;
                        end
                    end
                end
                PRESS: begin
                    if (scan_single && scan_code == cand_reg) begin
                        cnt_next = cnt_reg + 4'd1;
                        if (cnt_reg + 4'd1 == 4'(DEBOUNCE)) begin
                            state_next     = HELD;
                            kb_idx_next    = {1'b1, cand_reg};
                            key_pulse_next = 1'b1;
                        end
                    end else if (scan_single) begin
                        cand_next = scan_code;
                        cnt_next  = 4'd1;
                    end else begin
                        state_next = IDLE;
                        cnt_next   = 4'd0;
                    end
                end
                HELD: begin
                    if (scan_single && scan_code == cand_reg) begin
                        cnt_next = 4'd0;
                    end else if (DEBOUNCE == 1) begin
                        state_next  = IDLE;
                        cnt_next    = 4'd0;
                        kb_idx_next = {1'b0, kb_idx_reg[3:0]};
                    end else begin
                        state_next = RELEASE;
                        cnt_next   = 4'd1;
                    end
                end
                default: begin
                    // A returning held key re-enters HELD silently, with no new strobe.
                    if (scan_single && scan_code == cand_reg) begin
                        state_next = HELD;
                        cnt_next   = 4'd0;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                        if (cnt_reg + 4'd1 == 4'(DEBOUNCE)) begin
                            state_next  = IDLE;
                            cnt_next    = 4'd0;
                            kb_idx_next = {1'b0, kb_idx_reg[3:0]};
                        end
                    end
                end
            endcase
        end
    end

    assign cols      = cols_reg;
    assign kb_idx    = kb_idx_reg;
    assign key_pulse = key_pulse_reg;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=2) with a modelled
// keypad matrix and a commit scoreboard checked on every key_pulse.
module tb_keypad_scanner;
    logic        clkb = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [4:0]  kb_idx;
    logic        key_pulse;
    logic [15:0] press_mask = 16'h0000;   // bit r*4+c = key at row r, column c held

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    logic [4:0]  exp_q[$];
    logic [4:0]  mon_exp;
    logic [3:0]  exp_cols;

    always #5 clkb = ~clkb;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .clkb      (clkb),
        .rst       (rst),
        .rows      (rows),
        .cols      (cols),
        .kb_idx    (kb_idx),
        .key_pulse (key_pulse)
    );

    // A pressed key shorts its row low while its column is driven low.
    always_comb begin
        rows = 4'hf;
        for (int r = 0; r < 4; r++)
            rows[r] = ~|(press_mask[r*4 +: 4] & ~cols);
    end

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        $display("check %s observed=%b expected=%b", tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clkb);
        #1;
    endtask

    always @(negedge clkb) begin
        if (!rst && key_pulse === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL pulse_unexpected observed=%b expected=no_pulse", kb_idx);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pulse_code", kb_idx, mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and column sequencing
        step(3);
        check("rst_cols", {1'b0, cols}, 5'b01110);
        check("rst_kb_idx", kb_idx, 5'b00000);
        check("rst_pulse", {4'b0, key_pulse}, 5'b00000);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_cols = ~(4'b0001 << ((i / 4) % 4));
            check("col_seq", {1'b0, cols}, {1'b0, exp_cols});
            step(1);
        end
        step(9);
        rst = 1'b1;
        step(1);
        check("midscan_rst_cols", {1'b0, cols}, 5'b01110);
        check("midscan_rst_kb", kb_idx, 5'b00000);
        rst = 1'b0;

        // Single press of '6', then release
        press_mask = 16'h0040;
        exp_q.push_back(5'b10110);
        step(32);
        check("press6_latency", kb_idx, 5'b00000);
        step(1);
        check("press6_commit", kb_idx, 5'b10110);
        check("press6_pulse_hi", {4'b0, key_pulse}, 5'b00001);
        step(1);
        check("press6_pulse_lo", {4'b0, key_pulse}, 5'b00000);
        step(14);
        press_mask = 16'h0000;
        step(32);
        check("rel6_latency", kb_idx, 5'b10110);
        step(1);
        check("rel6_commit", kb_idx, 5'b00110);
        step(15);

        // Bounce on '#'
        press_mask = 16'h4000;
        step(16);
        press_mask = 16'h0000;
        step(16);
        press_mask = 16'h4000;
        exp_q.push_back(5'b11111);
        step(32);
        check("bounce_no_early", kb_idx, 5'b00110);
        step(1);
        check("bounce_commit", kb_idx, 5'b11111);
        step(15);
        press_mask = 16'h0000;
        step(33);
        check("bounce_release", kb_idx, 5'b01111);
        step(15);

        // Ghost: '1' and '5' together
        press_mask = 16'h0021;
        for (int s = 0; s < 5; s++) begin
            step(16);
            check("ghost_scan", kb_idx, 5'b01111);
        end
        step(1);
        check("ghost_final", kb_idx, 5'b01111);
        press_mask = 16'h0000;
        step(15);

        // 'A' for one scan, then 'D'
        press_mask = 16'h0008;
        step(16);
        press_mask = 16'h8000;
        exp_q.push_back(5'b11101);
        step(32);
        check("change_no_A", kb_idx, 5'b01111);
        step(1);
        check("change_commit_D", kb_idx, 5'b11101);
        step(15);
        press_mask = 16'h0000;
        step(33);
        check("change_release", kb_idx, 5'b01101);
        step(15);

        // '0' held with a one-scan dropout
        press_mask = 16'h2000;
        exp_q.push_back(5'b10000);
        step(33);
        check("hold0_commit", kb_idx, 5'b10000);
        step(15);
        press_mask = 16'h0000;
        step(16);
        press_mask = 16'h2000;
        step(1);
        check("hold0_dropout", kb_idx, 5'b10000);
        step(16);
        check("hold0_rehold", kb_idx, 5'b10000);

        // Reset while HELD, mid column 2
        step(8);
        rst = 1'b1;
        step(1);
        check("held_rst_kb", kb_idx, 5'b00000);
        check("held_rst_cols", {1'b0, cols}, 5'b01110);
        rst = 1'b0;
        press_mask = 16'h0000;
        step(48);
        check("post_rst_idle", kb_idx, 5'b00000);

        check("queue_empty", 5'(exp_q.size()), 5'd0);
        check("pulse_count", 5'(pulses), 5'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the board's 4×4 matrix keypad, debounces it, and produces the `kb_idx` word that the memory-mapped I/O reads at 0xffff_ff2c (key-valid bit) and 0xffff_ff30 (key code). It sits between the keypad pins and the CPU's MMIO read port:
- it drives the column lines;
- it synchronises the row lines;
- it rejects multi-key ghosting;
- it presents a stable, debounced key code.

## Interface
- SCAN_DIV, default 50000: clock cycles each column is driven. Legal minimum is 4.
- DEBOUNCE, default 4: consecutive identical full-scan results required to commit a press or a release. Legal range 1..15.
- clkb  in  1  system clock (same domain as the MMIO port).
- rst  in  1  reset, synchronous, active-high.
- rows  in  4  keypad row lines, active-low, asynchronous, pulled up.
- cols  out  4  keypad column drive, active-low one-hot.
- kb_idx  out  5  bit 4 is key held (debounced); bits 3:0 are the key code.
- key_pulse  out  1  one-cycle strobe when a new press is committed.

## Operation
- **Row synchroniser:** rows pass through 2 flops before use. No other logic touches raw rows.
- **Column sequencer:**
  - Column c (0..3) is driven by cols = ~(1<<c) for SCAN_DIV cycles, then c increments mod 4.
  - The divider runs 0..SCAN_DIV-1 and wraps.
  - One full scan is 4·SCAN_DIV cycles.
- **Row sampling:**
  - On the last divider cycle of column c (div == SCAN_DIV-1), the synchronised rows are inverted and stored as hit[c][3:0], with bit r meaning row r is pressed.
  - At that point the column has been stable for at least SCAN_DIV-1 cycles, which covers the synchroniser delay.
- **Key code map** (row r, column c):
  - r0: 1, 2, 3, A gives codes 1, 2, 3, 10.
  - r1: 4, 5, 6, B gives codes 4, 5, 6, 11.
  - r2: 7, 8, 9, C gives codes 7, 8, 9, 12.
  - r3: *, 0, #, D gives codes 14, 0, 15, 13.
- **Scan result:** evaluated in the cycle after the column-3 sample.
  - NONE: zero hits.
  - SINGLE(code): exactly one hit across all 16 bits.
  - MULTI: two or more hits. MULTI is treated as NONE.
- **Debounce FSM** (stable counter cnt, 4 bits):
  - **IDLE:**
    - SINGLE(k) → PRESS with cand=k, cnt=1.
    - If DEBOUNCE==1, go directly to HELD instead.
  - **PRESS:**
    - SINGLE(cand) → cnt+1. On reaching DEBOUNCE → HELD.
    - SINGLE(other k) → cand=k, cnt=1 (restart).
    - NONE or MULTI → IDLE.
  - **HELD:**
    - SINGLE(code) → stay, and set cnt=0.
    - Any other result → RELEASE, cnt=1.
    - If DEBOUNCE==1 → IDLE.
  - **RELEASE:**
    - SINGLE(code) → HELD.
    - Any other result → cnt+1. On reaching DEBOUNCE → IDLE.
- **Outputs:**
  - Entering HELD from PRESS or IDLE loads kb_idx[3:0]=cand, sets kb_idx[4]=1, and pulses key_pulse.
  - Entering IDLE from RELEASE or HELD clears kb_idx[4].
  - kb_idx[3:0] keeps the last committed code after release.
  - kb_idx[4]=1 in both HELD and RELEASE.
- **Reset** (synchronous, wins over everything):
  - State IDLE; div=0, c=0, cnt=0, cand=0, hit=0.
  - Synchroniser flops set to 4'hf.
  - cols=4'b1110, kb_idx=5'b00000, key_pulse=0.
  - Reset mid-scan discards all partial scan data. Reset in HELD drops kb_idx[4] the next cycle.

## Timing
- All outputs are registered and change only on the clkb rising edge.
- FSM and outputs update in the evaluation cycle. That cycle is 1 cycle after the column-3 sample, which is the first cycle of the next column-0 window.
- **Press latency:** a key pressed before the first sample of scan N commits at the evaluation of scan N+DEBOUNCE-1.
  - Worst case is DEBOUNCE+1 scans plus 3 cycles from press.
- **Release latency:** same as press latency.
- key_pulse is high for exactly 1 cycle per committed press. It never fires on release or on a HELD→RELEASE→HELD bounce.
- cols never shows more than one low bit. It shows all-high only never, because the sequencer always drives one column.

## Test plan
Parameters for all scenarios: SCAN_DIV=4, DEBOUNCE=2. One scan is 16 cycles.

1. **Reset:** assert rst mid-column 2 → next cycle cols=4'b1110 and kb_idx=0. Release rst → cols steps 1110, 1101, 1011, 0111, each held 4 cycles, then repeats.
2. **Single press:** model key '6' (r1,c2) so that rows[1]=0 whenever cols[2]=0 → after 2 full scans kb_idx=5'b1_0110 and key_pulse=1 for one cycle. Release → kb_idx[4]=0 after 2 NONE scans, with kb_idx[3:0]=6 retained.
3. **Bounce:** '#' (r3,c2) pressed for 1 scan, released for 1 scan, pressed for 2 scans → exactly one commit, kb_idx=5'b1_1111, one key_pulse.
4. **Ghost rejection:** '1' and '5' held together for 5 scans → kb_idx[4] stays 0, no key_pulse.
5. **Key change while pressing:** 'A' (r0,c3) for 1 scan, then 'D' (r3,c3) continuously → commit D (kb_idx=5'b1_1101) after 2 D-scans. A is never output.
6. **Hold with a dropout:** '0' committed, then 1 NONE scan inside HELD, then '0' again → kb_idx[4] stays 1 throughout and no second key_pulse.
